// File: rtl/cook_timer_ctrl.sv
// cook_timer_ctrl
// Kitchen countdown timer controller. mm:ss is set in IDLE with the
// increment buttons, counts down in RUN on the 1 Hz strobe, can be paused,
// and raises a self-clearing alarm when it reaches 00:00. All outputs come
// straight from registers.
module cook_timer_ctrl #(
  parameter int unsigned ALARM_SEC = 10
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clk_sec,
  input  logic       btn_start,
  input  logic       btn_inc_min,
  input  logic       btn_inc_sec,
  input  logic       btn_clear,
  output logic [3:0] min10,
  output logic [3:0] min1,
  output logic [3:0] sec10,
  output logic [3:0] sec1,
  output logic [1:0] state,
  output logic       alarm,
  output logic       done_pulse
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_ALARM = 2'd3
  } state_t;

  // Last value of the alarm counter before the timeout tick takes us out.
  localparam logic [5:0] ALARM_LAST = 6'(ALARM_SEC - 1);

  // Packed display value: [15:12] min10, [11:8] min1, [7:4] sec10, [3:0] sec1.
  state_t      state_r;
  logic [15:0] value_r;
  logic [15:0] preset_r;
  logic [5:0]  acnt_r;
  logic        alarm_r;
  logic        done_r;

  logic        any_btn_s;
  logic        value_zero_s;
  logic        value_last_s;
  logic        acnt_last_s;
  logic [7:0]  min_inc_s;
  logic [7:0]  sec_inc_s;
  logic [15:0] value_dec_s;

  // Increment a two-digit BCD pair modulo 60 (tens 0-5, units 0-9).
  function automatic logic [7:0] bcd_inc60(input logic [7:0] pair);
    logic [7:0] res;
    if (pair[3:0] == 4'd9) begin
      if (pair[7:4] >= 4'd5) begin
        res = 8'h00;
      end else begin
        res = {pair[7:4] + 4'd1, 4'd0};
      end
    end else begin
      res = {pair[7:4], pair[3:0] + 4'd1};
    end
    return res;
  endfunction

  // Decrement mm:ss by one second with BCD borrows; never called on 00:00.
  function automatic logic [15:0] mmss_dec(input logic [15:0] v);
    logic [3:0] m10;
    logic [3:0] m1;
    logic [3:0] s10;
    logic [3:0] s1;
    m10 = v[15:12];
    m1  = v[11:8];
    s10 = v[7:4];
    s1  = v[3:0];
    if (s1 != 4'd0) begin
      s1 = s1 - 4'd1;
    end else begin
      s1 = 4'd9;
      if (s10 != 4'd0) begin
        s10 = s10 - 4'd1;
      end else begin
        s10 = 4'd5;
        if (m1 != 4'd0) begin
          m1 = m1 - 4'd1;
        end else begin
          m1 = 4'd9;
          if (m10 != 4'd0) begin
            m10 = m10 - 4'd1;
          end else begin
            m10 = 4'd0;
          end
        end
      end
    end
    return {m10, m1, s10, s1};
  endfunction

  // Next-value candidates and decode flags shared by the state machine.
  always_comb begin
    any_btn_s    = btn_clear | btn_start | btn_inc_min | btn_inc_sec;
    value_zero_s = (value_r == 16'h0000);
    value_last_s = (value_r == 16'h0001);
    acnt_last_s  = (acnt_r == ALARM_LAST);
    min_inc_s    = bcd_inc60(value_r[15:8]);
    sec_inc_s    = bcd_inc60(value_r[7:0]);
    if (value_zero_s) begin
      value_dec_s = 16'h0000;
    end else begin
      value_dec_s = mmss_dec(value_r);
    end
  end

  // Timer state machine: button priority clear > start > inc_min > inc_sec.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r  <= ST_IDLE;
      value_r  <= 16'h0000;
      preset_r <= 16'h0000;
      acnt_r   <= 6'd0;
      alarm_r  <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (btn_clear) begin
            value_r <= 16'h0000;
          end else if (btn_start) begin
            // A start at 00:00 is swallowed and blocks the lower buttons.
            if (!value_zero_s) begin
              preset_r <= value_r;
              state_r  <= ST_RUN;
            end else begin
              state_r  <= ST_IDLE;
            end
          end else if (btn_inc_min) begin
            value_r[15:8] <= min_inc_s;
          end else if (btn_inc_sec) begin
            value_r[7:0] <= sec_inc_s;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_RUN: begin
          if (btn_clear) begin
            value_r <= 16'h0000;
            state_r <= ST_IDLE;
          end else if (btn_start) begin
            // A coincident tick is dropped so the paused value is exact.
            state_r <= ST_PAUSE;
          end else if (clk_sec) begin
            if (value_last_s) begin
              value_r <= 16'h0000;
              state_r <= ST_ALARM;
              alarm_r <= 1'b1;
              done_r  <= 1'b1;
              acnt_r  <= 6'd0;
            end else begin
              value_r <= value_dec_s;
            end
          end else begin
            state_r <= ST_RUN;
          end
        end
        ST_PAUSE: begin
          if (btn_clear) begin
            value_r <= 16'h0000;
            state_r <= ST_IDLE;
          end else if (btn_start) begin
            state_r <= ST_RUN;
          end else begin
            state_r <= ST_PAUSE;
          end
        end
        ST_ALARM: begin
          if (any_btn_s) begin
            // Buttons override a coincident tick; only clear discards the preset.
            state_r <= ST_IDLE;
            alarm_r <= 1'b0;
            acnt_r  <= 6'd0;
            if (btn_clear) begin
              value_r <= 16'h0000;
            end else begin
              value_r <= preset_r;
            end
          end else if (clk_sec) begin
            if (acnt_last_s) begin
              state_r <= ST_IDLE;
              alarm_r <= 1'b0;
              acnt_r  <= 6'd0;
              value_r <= preset_r;
            end else begin
              acnt_r <= acnt_r + 6'd1;
            end
          end else begin
            state_r <= ST_ALARM;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          value_r <= 16'h0000;
          acnt_r  <= 6'd0;
          alarm_r <= 1'b0;
        end
      endcase
    end
  end

  assign state      = state_r;
  assign min10      = value_r[15:12];
  assign min1       = value_r[11:8];
  assign sec10      = value_r[7:4];
  assign sec1       = value_r[3:0];
  assign alarm      = alarm_r;
  assign done_pulse = done_r;

endmodule

// File: tb/tb_cook_timer_ctrl.sv
// Directed bench for cook_timer_ctrl: a vector table plus hand sequences.
module tb_cook_timer_ctrl;

  logic       clk;
  logic       reset_n;
  logic       clk_sec;
  logic       btn_start;
  logic       btn_inc_min;
  logic       btn_inc_sec;
  logic       btn_clear;
  logic [3:0] min10;
  logic [3:0] min1;
  logic [3:0] sec10;
  logic [3:0] sec1;
  logic [1:0] state;
  logic       alarm;
  logic       done_pulse;

  int n_checks = 0;
  int n_pass   = 0;

  // btn bits: {clear, start, inc_min, inc_sec, tick}
  typedef struct {
    logic [4:0]  btn;
    logic [1:0]  st;
    logic [15:0] val;
    logic        al;
    logic        dp;
  } vec_t;

  localparam int NV = 24;
  vec_t tbl[NV];

  cook_timer_ctrl #(.ALARM_SEC(10)) dut (
    .clk(clk), .reset_n(reset_n), .clk_sec(clk_sec),
    .btn_start(btn_start), .btn_inc_min(btn_inc_min),
    .btn_inc_sec(btn_inc_sec), .btn_clear(btn_clear),
    .min10(min10), .min1(min1), .sec10(sec10), .sec1(sec1),
    .state(state), .alarm(alarm), .done_pulse(done_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input logic [4:0] b);
    {btn_clear, btn_start, btn_inc_min, btn_inc_sec, clk_sec} = b;
    @(posedge clk);
    #1;
    {btn_clear, btn_start, btn_inc_min, btn_inc_sec, clk_sec} = 5'b00000;
  endtask

  task automatic check(input string nm, input logic [1:0] es, input logic [15:0] ev,
                       input logic ea, input logic ed);
    logic [19:0] got;
    logic [19:0] exp;
    got = {state, min10, min1, sec10, sec1, alarm, done_pulse};
    exp = {es, ev, ea, ed};
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got st=%0d %h%h:%h%h al=%b dp=%b, expected st=%0d %h:%h al=%b dp=%b",
               nm, state, min10, min1, sec10, sec1, alarm, done_pulse,
               es, ev[15:8], ev[7:0], ea, ed);
    end
  endtask

  initial begin
    tbl[0]  = '{5'b00010, 2'd0, 16'h0001, 1'b0, 1'b0};
    tbl[1]  = '{5'b00010, 2'd0, 16'h0002, 1'b0, 1'b0};
    tbl[2]  = '{5'b00010, 2'd0, 16'h0003, 1'b0, 1'b0};
    tbl[3]  = '{5'b01000, 2'd1, 16'h0003, 1'b0, 1'b0};
    tbl[4]  = '{5'b00001, 2'd1, 16'h0002, 1'b0, 1'b0};
    tbl[5]  = '{5'b00001, 2'd1, 16'h0001, 1'b0, 1'b0};
    tbl[6]  = '{5'b00001, 2'd3, 16'h0000, 1'b1, 1'b1};
    tbl[7]  = '{5'b00000, 2'd3, 16'h0000, 1'b1, 1'b0};
    tbl[8]  = '{5'b00100, 2'd0, 16'h0003, 1'b0, 1'b0};
    tbl[9]  = '{5'b00110, 2'd0, 16'h0103, 1'b0, 1'b0};
    tbl[10] = '{5'b01100, 2'd1, 16'h0103, 1'b0, 1'b0};
    tbl[11] = '{5'b00001, 2'd1, 16'h0102, 1'b0, 1'b0};
    tbl[12] = '{5'b00010, 2'd1, 16'h0102, 1'b0, 1'b0};
    tbl[13] = '{5'b01001, 2'd2, 16'h0102, 1'b0, 1'b0};
    tbl[14] = '{5'b00001, 2'd2, 16'h0102, 1'b0, 1'b0};
    tbl[15] = '{5'b00100, 2'd2, 16'h0102, 1'b0, 1'b0};
    tbl[16] = '{5'b01000, 2'd1, 16'h0102, 1'b0, 1'b0};
    tbl[17] = '{5'b11000, 2'd0, 16'h0000, 1'b0, 1'b0};
    tbl[18] = '{5'b01000, 2'd0, 16'h0000, 1'b0, 1'b0};
    tbl[19] = '{5'b01010, 2'd0, 16'h0000, 1'b0, 1'b0};
    tbl[20] = '{5'b00100, 2'd0, 16'h0100, 1'b0, 1'b0};
    tbl[21] = '{5'b01000, 2'd1, 16'h0100, 1'b0, 1'b0};
    tbl[22] = '{5'b00001, 2'd1, 16'h0059, 1'b0, 1'b0};
    tbl[23] = '{5'b10000, 2'd0, 16'h0000, 1'b0, 1'b0};

    reset_n = 1'b0;
    {btn_clear, btn_start, btn_inc_min, btn_inc_sec, clk_sec} = 5'b00000;
    #12;
    check("reset_state", 2'd0, 16'h0000, 1'b0, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("after_release", 2'd0, 16'h0000, 1'b0, 1'b0);

    for (int i = 0; i < NV; i++) begin
      step(tbl[i].btn);
      check($sformatf("vec%0d", i), tbl[i].st, tbl[i].val, tbl[i].al, tbl[i].dp);
    end

    // 10:00 -> 09:59 borrow through every digit
    for (int i = 0; i < 10; i++) step(5'b00100);
    check("set_10_00", 2'd0, 16'h1000, 1'b0, 1'b0);
    step(5'b01000);
    step(5'b00001);
    check("dec_10_00", 2'd1, 16'h0959, 1'b0, 1'b0);
    step(5'b10000);

    // 60 second increments wrap without touching minutes
    step(5'b00100);
    for (int i = 1; i <= 60; i++) begin
      step(5'b00010);
      if (i == 59) check("sec_59", 2'd0, 16'h0159, 1'b0, 1'b0);
      if (i == 60) check("sec_wrap", 2'd0, 16'h0100, 1'b0, 1'b0);
    end
    step(5'b10000);

    // alarm timeout after exactly ten ticks, reload preset 00:03
    for (int i = 0; i < 3; i++) step(5'b00010);
    step(5'b01000);
    for (int i = 0; i < 3; i++) step(5'b00001);
    check("alarm_entry", 2'd3, 16'h0000, 1'b1, 1'b1);
    for (int i = 1; i <= 10; i++) begin
      step(5'b00000);
      step(5'b00001);
      if (i < 10) check($sformatf("alarm_tick%0d", i), 2'd3, 16'h0000, 1'b1, 1'b0);
      else        check("alarm_timeout", 2'd0, 16'h0003, 1'b0, 1'b0);
    end

    // clear coinciding with a tick in ALARM exits with 00:00
    step(5'b01000);
    for (int i = 0; i < 3; i++) step(5'b00001);
    check("alarm_again", 2'd3, 16'h0000, 1'b1, 1'b1);
    step(5'b10001);
    check("alarm_clear", 2'd0, 16'h0000, 1'b0, 1'b0);

    // asynchronous reset in the middle of RUN
    for (int i = 0; i < 5; i++) step(5'b00010);
    step(5'b01000);
    step(5'b00001);
    check("pre_reset_run", 2'd1, 16'h0004, 1'b0, 1'b0);
    #3;
    reset_n = 1'b0;
    #1;
    check("async_reset", 2'd0, 16'h0000, 1'b0, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    step(5'b01000);
    check("start_after_reset", 2'd0, 16'h0000, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
